// File: rtl/debug_unit_pkg.sv
// Shared constants for the debug unit: command bytes, FSM encoding and dump layout.
package debug_unit_pkg;

  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  localparam int N_GPR          = 32;
  localparam int N_FIXED_WORDS  = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STEP    = 3'd1,
    ST_RUN     = 3'd2,
    ST_LOAD    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRC_PC  = 2'd0,
    SRC_ALU = 2'd1,
    SRC_REG = 2'd2,
    SRC_MEM = 2'd3
  } src_t;

  function automatic int dump_words(input int tam_data_memory);
    return N_FIXED_WORDS + N_GPR + tam_data_memory;
  endfunction

endpackage

// File: rtl/debug_word_sender.sv
// Holds one dump word and presents it MSB-first, one byte per transmit handshake.
module debug_word_sender
  import debug_unit_pkg::*;
#(
  parameter int NB = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [NB-1:0] i_word,
  input  logic          i_start,
  input  logic          i_next_byte,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_start,
  output logic          o_last_byte
);

  logic [NB-1:0] r_word;
  logic [1:0]    r_byte_idx;
  logic [7:0]    r_tx_data;
  logic          r_tx_start;
  logic [1:0]    w_next_idx;
  logic [NB-1:0] w_next_shift;

  assign w_next_idx   = r_byte_idx + 2'd1;
  assign w_next_shift = r_word << {w_next_idx, 3'b000};

  // Word latch, byte pointer and registered transmit outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_word     <= '0;
      r_byte_idx <= 2'd0;
      r_tx_data  <= 8'd0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= i_start;
      if (i_load) begin
        r_word     <= i_word;
        r_byte_idx <= 2'd0;
        r_tx_data  <= i_word[NB-1 -: 8];
      end else if (i_next_byte) begin
        r_byte_idx <= w_next_idx;
        r_tx_data  <= w_next_shift[NB-1 -: 8];
      end
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/debug_unit.sv
// Debug controller: decodes UART commands to step/run the MIPS pipeline and
// dumps PC, ALU result, all GPRs and the first data-memory words as bytes.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int NB              = 32,
  parameter int NB_REG_SEL      = 5,
  parameter int TAM_DATA_MEMORY = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  input  logic [NB-1:0]         i_mips_pc,
  input  logic [NB-1:0]         i_mips_alu_result,
  input  logic [NB-1:0]         i_mips_register_data,
  input  logic [NB-1:0]         i_mips_data_memory,
  input  logic                  i_mips_halt,
  output logic                  o_step,
  output logic [NB_REG_SEL-1:0] o_debug_mips_register_number,
  output logic [NB-1:0]         o_debug_address
);

  localparam int N_WORDS   = dump_words(TAM_DATA_MEMORY);
  localparam int NB_ITEM   = $clog2(N_WORDS + 1);
  localparam int FIRST_MEM = N_FIXED_WORDS + N_GPR;

  state_t                r_state;
  state_t                w_next_state;
  logic [NB_ITEM-1:0]    r_item;
  logic                  r_load_phase;
  logic [NB_REG_SEL-1:0] r_reg_num;
  logic [NB-1:0]         r_address;

  logic               w_load;
  logic               w_start;
  logic               w_next_byte;
  logic               w_item_clr;
  logic               w_item_inc;
  logic               w_last_byte;
  logic               w_last_item;
  src_t               w_src;
  logic [NB-1:0]      w_word;
  logic [NB_ITEM-1:0] w_mem_index;
  logic [NB-1:0]      w_addr_ext;

  assign w_last_item = (r_item == NB_ITEM'(N_WORDS - 1));
  assign w_mem_index = r_item - NB_ITEM'(FIRST_MEM);
  assign w_addr_ext  = NB'(w_mem_index);

  // Which pipeline source feeds the current dump item.
  always_comb begin
    if (r_item == NB_ITEM'(0)) begin
      w_src = SRC_PC;
    end else if (r_item == NB_ITEM'(1)) begin
      w_src = SRC_ALU;
    end else if (r_item < NB_ITEM'(FIRST_MEM)) begin
      w_src = SRC_REG;
    end else begin
      w_src = SRC_MEM;
    end
  end

  // Word mux sampled on the second LOAD cycle, once the selectors have settled.
  always_comb begin
    case (w_src)
      SRC_PC:  w_word = i_mips_pc;
      SRC_ALU: w_word = i_mips_alu_result;
      SRC_REG: w_word = i_mips_register_data;
      SRC_MEM: w_word = i_mips_data_memory;
      default: w_word = '0;
    endcase
  end

  // Next-state and control-strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_start      = 1'b0;
    w_next_byte  = 1'b0;
    w_item_clr   = 1'b0;
    w_item_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_item_clr = 1'b1;
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_STEP: w_next_state = ST_STEP;
            CMD_CONT: w_next_state = i_mips_halt ? ST_LOAD : ST_RUN;
            CMD_DUMP: w_next_state = ST_LOAD;
            default:  w_next_state = ST_IDLE;
          endcase
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STEP: w_next_state = ST_LOAD;
      ST_RUN: begin
        if (i_mips_halt) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (r_load_phase) begin
          w_load       = 1'b1;
          w_start      = 1'b1;
          w_next_state = ST_SEND;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_SEND: w_next_state = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (!w_last_byte) begin
            w_next_byte  = 1'b1;
            w_start      = 1'b1;
            w_next_state = ST_SEND;
          end else if (w_last_item) begin
            w_next_state = ST_IDLE;
          end else begin
            w_item_inc   = 1'b1;
            w_next_state = ST_LOAD;
          end
        end else begin
          w_next_state = ST_WAIT_TX;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Step enable: one cycle in STEP, continuous in RUN until halt is seen.
  always_comb begin
    if (r_state == ST_STEP) begin
      o_step = 1'b1;
    end else if (r_state == ST_RUN) begin
      o_step = ~i_mips_halt;
    end else begin
      o_step = 1'b0;
    end
  end

  // State, item counter, LOAD sub-phase and read selectors.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_item       <= '0;
      r_load_phase <= 1'b0;
      r_reg_num    <= '0;
      r_address    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_item_clr) begin
        r_item <= '0;
      end else if (w_item_inc) begin
        r_item <= r_item + NB_ITEM'(1);
      end
      r_load_phase <= (r_state == ST_LOAD) ? ~r_load_phase : 1'b0;
      if ((r_state == ST_LOAD) && !r_load_phase) begin
        // GPR items start at 2, so the low bits minus 2 wrap to the GPR index.
        if (w_src == SRC_REG) begin
          r_reg_num <= r_item[NB_REG_SEL-1:0] - NB_REG_SEL'(N_FIXED_WORDS);
        end
        if (w_src == SRC_MEM) begin
          r_address <= w_addr_ext << 2;
        end
      end
    end
  end

  assign o_debug_mips_register_number = r_reg_num;
  assign o_debug_address              = r_address;

  debug_word_sender #(
    .NB(NB)
  ) u_sender (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_word      (w_word),
    .i_start     (w_start),
    .i_next_byte (w_next_byte),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_last_byte (w_last_byte)
  );

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: a MIPS/UART model feeds the DUT, expected
// dump bytes are queued per command and checked by an independent tx monitor.
module tb_debug_unit;

  localparam int NB      = 32;
  localparam int TAM     = 16;
  localparam int N_BYTES = 4 * (2 + 32 + TAM);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic [31:0] pc;
  logic [31:0] alu;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic        halt;
  logic        step;
  logic [4:0]  reg_num;
  logic [31:0] addr;

  logic [31:0] regs [32];
  logic [31:0] mem  [TAM];
  logic [31:0] base_pc;
  logic [31:0] halt_pc;

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int tests = 0;
  int fails = 0;
  int steps_seen = 0;
  int starts = 0;
  int dones = 0;
  int tx_delay = 0;
  bit outstanding = 1'b0;
  int delay_cnt = 0;
  logic [7:0] held;

  always #5 clk = ~clk;

  debug_unit #(.NB(NB), .NB_REG_SEL(5), .TAM_DATA_MEMORY(TAM)) dut (
    .i_clk                        (clk),
    .i_reset                      (rst_n),
    .i_rx_data                    (rx_data),
    .i_rx_valid                   (rx_valid),
    .o_tx_data                    (tx_data),
    .o_tx_start                   (tx_start),
    .i_tx_done                    (tx_done),
    .i_mips_pc                    (pc),
    .i_mips_alu_result            (alu),
    .i_mips_register_data         (reg_data),
    .i_mips_data_memory           (mem_data),
    .i_mips_halt                  (halt),
    .o_step                       (step),
    .o_debug_mips_register_number (reg_num),
    .o_debug_address              (addr)
  );

  // Pipeline model: each stepped edge advances the PC by one instruction.
  assign pc       = base_pc + 32'(steps_seen) * 32'd4;
  assign halt     = (pc >= halt_pc);
  assign reg_data = regs[reg_num];
  assign mem_data = (addr[31:6] == 26'd0) ? mem[addr[5:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (step) steps_seen <= steps_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // UART model and scoreboard monitor.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      outstanding = 1'b0;
    end else if (tx_start) begin
      starts++;
      check("no_overlap", {31'd0, outstanding}, 32'd0);
      got_q.push_back(tx_data);
      if (exp_q.size() == 0) begin
        check("unexpected_tx", 32'd1, 32'd0);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      outstanding = 1'b1;
      held = tx_data;
      delay_cnt = tx_delay;
    end else if (outstanding) begin
      if (delay_cnt == 0) begin
        check("tx_data_stable", {24'd0, tx_data}, {24'd0, held});
        tx_done = 1'b1;
        dones++;
        outstanding = 1'b0;
      end else begin
        delay_cnt--;
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
  endtask

  task automatic push_dump(input logic [31:0] pc_final);
    push_word(pc_final);
    push_word(alu);
    for (int r = 0; r < 32; r++) push_word(regs[r]);
    for (int m = 0; m < TAM; m++) push_word(mem[m]);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_dump_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || outstanding) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("dump_timeout", 32'd1, 32'd0);
    repeat (8) @(negedge clk);
  endtask

  // Issue one command; the reference model predicts step count and final PC.
  task automatic run_cmd(input logic [7:0] cmd, input bit inject);
    int s0, st0, d0, exp_steps;
    logic [31:0] pc_final;
    s0 = steps_seen; st0 = starts; d0 = dones;
    got_q.delete();
    if (cmd == 8'h73) begin
      exp_steps = 1;
    end else if (cmd == 8'h63 && pc < halt_pc) begin
      exp_steps = int'((halt_pc - pc) / 32'd4);
    end else begin
      exp_steps = 0;
    end
    pc_final = pc + 32'(exp_steps) * 32'd4;
    push_dump(pc_final);
    send_rx(cmd);
    if (inject) begin
      repeat (300) @(negedge clk);
      send_rx(8'h78);
      repeat (100) @(negedge clk);
      send_rx(8'h73);
    end
    wait_dump_done(20000);
    check("step_count", 32'(steps_seen - s0), 32'(exp_steps));
    check("tx_starts", 32'(starts - st0), 32'(N_BYTES));
    check("tx_dones", 32'(dones - d0), 32'(N_BYTES));
    check("step_idle", {31'd0, step}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_step"}, {31'd0, step}, 32'd0);
    check({tag, "_reg_num"}, {27'd0, reg_num}, 32'd0);
    check({tag, "_addr"}, addr, 32'd0);
  endtask

  task automatic randomize_model();
    alu = $urandom;
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    for (int m = 0; m < TAM; m++) mem[m] = $urandom;
  endtask

  initial begin
    int st0, s0, n;
    logic [7:0] cmds [3];
    cmds[0] = 8'h73; cmds[1] = 8'h63; cmds[2] = 8'h64;
    rst_n = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    base_pc = 32'd0; halt_pc = 32'd1000;
    randomize_model();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unknown command byte is ignored.
    st0 = starts; s0 = steps_seen;
    send_rx(8'h41);
    repeat (20) @(negedge clk);
    check("unknown_no_tx", 32'(starts - st0), 32'd0);
    check("unknown_no_step", 32'(steps_seen - s0), 32'd0);

    // Single step from PC 0 with a fixed ALU value.
    alu = 32'hFFFF_FBF9;
    run_cmd(8'h73, 1'b0);
    if (got_q.size() >= 8) begin
      check("step_b0", {24'd0, got_q[0]}, 32'h00);
      check("step_b3", {24'd0, got_q[3]}, 32'h04);
      check("step_b4", {24'd0, got_q[4]}, 32'hFF);
      check("step_b6", {24'd0, got_q[6]}, 32'hFB);
      check("step_b7", {24'd0, got_q[7]}, 32'hF9);
    end else begin
      check("step_got_bytes", 32'(got_q.size()), 32'd8);
    end

    // Dump only, with index-valued registers and memory.
    for (int r = 0; r < 32; r++) regs[r] = 32'(r);
    for (int m = 0; m < TAM; m++) mem[m] = 32'(m);
    run_cmd(8'h64, 1'b0);
    for (int k = 0; k < 32 + TAM; k++) begin
      if (got_q.size() > 8 + 4 * k + 3)
        check("dump_index", {24'd0, got_q[8 + 4 * k + 3]}, 32'(k % 32));
    end

    // Continue until halt after ten instructions.
    halt_pc = pc + 32'd40;
    run_cmd(8'h63, 1'b0);

    // Continue while already halted: no step at all.
    run_cmd(8'h63, 1'b0);

    // Slow transmitter with stray commands mid-dump.
    tx_delay = 50;
    randomize_model();
    run_cmd(8'h64, 1'b1);

    // Reset in the middle of a dump, then a fresh dump.
    tx_delay = 2;
    st0 = starts;
    push_dump(pc);
    send_rx(8'h64);
    n = 0;
    while ((starts - st0) < 57 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte_57", 32'(starts - st0), 32'd57);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(8'h64, 1'b0);
    check("fresh_pc_b3", {24'd0, got_q[3]}, {24'd0, pc[7:0]});

    // Randomized command mix.
    for (int it = 0; it < 6; it++) begin
      randomize_model();
      tx_delay = int'($urandom_range(0, 3));
      halt_pc = pc + 32'd4 * 32'($urandom_range(0, 12));
      run_cmd(cmds[$urandom_range(0, 2)], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
